// File: rtl/sprite_dma.sv
// Copies one sprite record (bitmap rows, X, Y) from main memory into sprite RAM,
// starting only on a vsync rising edge so the RAM never changes mid-frame.
module sprite_dma #(
    parameter int RECORD_BYTES = 10,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic              vsync,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [7:0]        mem_data,
    output logic              spr_we,
    output logic [3:0]        spr_addr,
    output logic [7:0]        spr_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, ARMED, REQ, WRITE, DONE} state_t;

    localparam logic [3:0] LAST = 4'(RECORD_BYTES - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base, next_base;
    logic [3:0]        index;
    logic              pending, vsync_q, vsync_edge, rearm;

    assign vsync_edge = vsync & ~vsync_q;
    // A start landing in the DONE cycle is treated like a pending one.
    assign rearm      = pending | start;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)      state_nx = ARMED;
            ARMED:   if (vsync_edge) state_nx = REQ;
            REQ:     if (mem_valid)  state_nx = WRITE;
            WRITE:   state_nx = (index == LAST) ? DONE : REQ;
            DONE:    state_nx = rearm ? ARMED : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign mem_rd   = (state == REQ);
    assign mem_addr = mem_rd ? base + ADDR_W'(index) : '0;
    assign spr_we   = (state == WRITE);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            base      <= '0;
            next_base <= '0;
            index     <= '0;
            pending   <= 1'b0;
            vsync_q   <= 1'b0;
            spr_addr  <= '0;
            spr_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state   <= state_nx;
            vsync_q <= vsync;
            // Queue a follow-on record; the active copy is left untouched.
            if (start && busy && state != DONE) begin
                pending   <= 1'b1;
                next_base <= src_base;
            end
            case (state)
                IDLE: if (start) begin
                    base  <= src_base;
                    index <= '0;
                    busy  <= 1'b1;
                end
                REQ: if (mem_valid) begin
                    spr_addr <= index;
                    spr_data <= mem_data;
                end
                WRITE: if (index != LAST) index <= index + 4'd1;
                DONE: begin
                    pending <= 1'b0;
                    index   <= '0;
                    if (rearm) base <= start ? src_base : next_base;
                    else       busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_dma.sv
// Scoreboard bench for sprite_dma: stimulus queues expected reads/writes, monitor pops and compares.
module tb_sprite_dma;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, vsync = 1'b0, mem_valid = 1'b0;
    logic [15:0] src_base = '0;
    logic [7:0]  mem_data = '0;
    logic        mem_rd, spr_we, busy, done;
    logic [15:0] mem_addr;
    logic [3:0]  spr_addr;
    logic [7:0]  spr_data;

    sprite_dma #(.RECORD_BYTES(10), .ADDR_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .src_base(src_base), .vsync(vsync),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
        .spr_we(spr_we), .spr_addr(spr_addr), .spr_data(spr_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0, done_cnt = 0, rd_delay = 0, wait_n = 0;
    bit          rd_allowed = 1'b0, prev_rd = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [15:0] exp_rd[$];
    logic [11:0] exp_wr[$];

    function automatic logic [7:0] mem_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check(name, {mem_rd, mem_addr, spr_we, spr_addr, spr_data, busy, done}, 32'h0);
    endtask

    // Memory model: answers each read after rd_delay extra cycles
    initial forever begin
        @(negedge clk);
        if (mem_rd && reset) begin
            repeat (rd_delay) @(negedge clk);
            mem_data  = mem_val(mem_addr);
            mem_valid = 1'b1;
            @(negedge clk);
            mem_valid = 1'b0;
        end
    end

    // Monitor
    initial forever begin
        @(negedge clk);
        if (mem_rd) begin
            if (!prev_rd) begin
                check("rd_after_vsync", {31'd0, rd_allowed}, 32'd1);
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got read at %h expected none", mem_addr);
                end else check("rd_addr", {16'd0, mem_addr}, {16'd0, exp_rd.pop_front()});
            end else begin
                check("rd_addr_stable", {16'd0, mem_addr}, {16'd0, prev_addr});
            end
        end
        prev_rd   = mem_rd;
        prev_addr = mem_addr;
        if (spr_we) begin
            if (exp_wr.size() == 0) begin
                checks++; errors++;
                $display("FAIL spr_unexpected: got write %h/%h expected none", spr_addr, spr_data);
            end else check("spr_write", {20'd0, spr_addr, spr_data}, {20'd0, exp_wr.pop_front()});
        end
        if (done) done_cnt++;
    end

    task automatic arm(input logic [15:0] b, input bit with_vsync);
        @(negedge clk);
        start    = 1'b1;
        src_base = b;
        if (with_vsync) vsync = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [15:0] a;
            a = b + 16'(i);
            exp_rd.push_back(a);
            exp_wr.push_back({4'(i), mem_val(a)});
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic vsync_rise();
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        vsync      = 1'b1;
        rd_allowed = 1'b1;
    endtask

    task automatic wait_done(input string name, input bit exp_busy);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 400);
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no done expected done within 400 cycles", name);
        end
        rd_allowed = 1'b0;
        check({name, "_busy_at_done"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        check({name, "_busy_after"}, {31'd0, busy}, {31'd0, exp_busy});
        check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
        if (!exp_busy) check({name, "_wr_left"}, exp_wr.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check_idle("reset_state");
        reset = 1'b1;

        // 1: basic copy, vsync 5 cycles after arming
        rd_delay = 0;
        arm(16'h1200, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("t1_armed_busy", {31'd0, busy}, 32'd1);
        end
        vsync_rise();
        wait_done("t1", 1'b0);

        // 2: slow memory
        rd_delay = 3;
        arm(16'h2400, 1'b0);
        repeat (2) @(negedge clk);
        vsync_rise();
        wait_done("t2", 1'b0);

        // 3: address wrap
        rd_delay = 1;
        arm(16'hFFFC, 1'b0);
        vsync_rise();
        wait_done("t3", 1'b0);

        // 4: queued second record plus a vsync edge mid-copy
        rd_delay = 0;
        arm(16'h2000, 1'b0);
        vsync_rise();
        repeat (3) @(negedge clk);
        arm(16'h3000, 1'b0);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        vsync = 1'b1;
        wait_done("t4a", 1'b1);
        repeat (5) @(negedge clk);
        check("t4_waiting_busy", {31'd0, busy}, 32'd1);
        vsync_rise();
        wait_done("t4b", 1'b0);

        // 5: reset during WRITE of index 4
        arm(16'h4000, 1'b0);
        vsync_rise();
        wait_n = 0;
        do begin
            @(negedge clk);
            wait_n++;
        end while (!(spr_we && spr_addr == 4'd4) && wait_n < 200);
        if (!(spr_we && spr_addr == 4'd4)) begin
            checks++; errors++;
            $display("FAIL t5_timeout: got no write of index 4 expected one");
        end
        #1 reset = 1'b0;
        rd_allowed = 1'b0;
        #1 check_idle("t5_reset_mid");
        exp_rd.delete();
        exp_wr.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_idle("t5_after_release");
        end
        arm(16'h4100, 1'b0);
        vsync_rise();
        wait_done("t5", 1'b0);

        // 6: start and vsync edge in the same cycle
        @(negedge clk);
        vsync = 1'b0;
        arm(16'h5000, 1'b1);
        repeat (6) begin
            @(negedge clk);
            check("t6_armed_busy", {31'd0, busy}, 32'd1);
        end
        vsync_rise();
        wait_done("t6", 1'b0);

        check("done_count", done_cnt, 32'd7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
